// File: rtl/shift_deser_32bit_if.sv
// Bus between a serial bit source / parallel consumer and the deserializer.
// The slave view is the deserializer; the master view drives it.
interface shift_deser_32bit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             Dir;
    logic             SIn;
    logic             SValid;
    logic             out_ready;
    logic [WIDTH-1:0] PData;
    logic             PValid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, Dir, SIn, SValid, out_ready,
        input  PData, PValid, busy, overrun
    );

    modport slave (
        input  start, Dir, SIn, SValid, out_ready,
        output PData, PValid, busy, overrun
    );
endinterface

// File: rtl/shift_deser_32bit.sv
// Serial-to-parallel receiver: gathers WIDTH bits MSB- or LSB-first and presents
// the word on a held parallel output with a valid/ready handshake. A completed
// word that finds the output still occupied is dropped and flagged as overrun.
module shift_deser_32bit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic                 clk,
    input logic                 clear,
    shift_deser_32bit_if.slave  bus
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RECV = 1'b1;

    logic             r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_pdata;
    logic             r_pvalid;
    logic             r_overrun;

    logic             w_dir;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;
    logic             w_done;

    // Shift candidate and completion decode; a start relatches the order for its own bit.
    always_comb begin
        w_dir     = bus.start ? bus.Dir : r_dir;
        w_shifted = w_dir ? {bus.SIn, r_sreg[WIDTH-1:1]} : {r_sreg[WIDTH-2:0], bus.SIn};
        w_last    = (r_cnt == CNT_W'(WIDTH - 1));
        // start wins over completion, so an aborting start never yields a word
        w_done    = (r_state == ST_RECV) && !bus.start && bus.SValid && w_last;
    end

    // Frame FSM, shift register, delivery and sticky overrun.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= ST_IDLE;
            r_dir     <= 1'b0;
            r_sreg    <= '0;
            r_cnt     <= '0;
            r_pdata   <= '0;
            r_pvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (bus.start) begin
                // stale partial bits stay in sreg; a full frame shifts them out
                r_dir   <= bus.Dir;
                r_state <= ST_RECV;
                if (bus.SValid) begin
                    r_sreg <= w_shifted;
                    r_cnt  <= CNT_W'(1);
                end else begin
                    r_cnt  <= '0;
                end
            end else if ((r_state == ST_RECV) && bus.SValid) begin
                r_sreg <= w_shifted;
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            if (w_done) begin
                if (!r_pvalid || bus.out_ready) begin
                    r_pdata  <= w_shifted;
                    r_pvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_pvalid && bus.out_ready) begin
                r_pvalid <= 1'b0;
            end
        end
    end

    assign bus.PData   = r_pdata;
    assign bus.PValid  = r_pvalid;
    assign bus.busy    = (r_state == ST_RECV);
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_shift_deser_32bit.sv
// Bench for shift_deser_32bit: directed frames with hand-computed words pushed
// to a scoreboard queue; a negedge monitor pops on each newly delivered word.
module tb_shift_deser_32bit;

    logic clk;
    logic clear;
    int   n_cmp;
    int   n_bad;

    logic [31:0] exp_q[$];
    logic [31:0] last_word;
    logic        prev_pvalid;
    logic        prev_ready;

    shift_deser_32bit_if #(.WIDTH(32)) bus ();

    shift_deser_32bit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a word is new when PValid rises or a transfer happened on the last edge.
    initial begin
        prev_pvalid = 1'b0;
        prev_ready  = 1'b0;
        last_word   = '0;
        forever begin
            @(negedge clk);
            if (bus.PValid === 1'b1) begin
                if (!prev_pvalid || prev_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got 0x%08h, expected no word", bus.PData);
                    end else begin
                        check("word", bus.PData, exp_q.pop_front());
                    end
                    last_word = bus.PData;
                end else begin
                    check("hold", bus.PData, last_word);
                end
            end
            prev_pvalid = bus.PValid;
            prev_ready  = bus.out_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.SValid = 1'b1;
        bus.SIn    = b;
        tick();
        bus.SValid = 1'b0;
    endtask

    task automatic start_cycle(input logic dir);
        bus.start = 1'b1;
        bus.Dir   = dir;
        tick();
        bus.start = 1'b0;
    endtask

    // Full MSB-first frame: start cycle, then 32 contiguous bits.
    task automatic send_msb(input logic [31:0] w);
        start_cycle(1'b0);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_clear(input int cycles);
        clear = 1'b1;
        repeat (cycles) tick();
        clear = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.Dir       = 1'b0;
        bus.SIn       = 1'b0;
        bus.SValid    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        clear = 1'b0;

        check("rst_pdata",   bus.PData,           32'h0);
        check("rst_pvalid",  32'(bus.PValid),     32'h0);
        check("rst_busy",    32'(bus.busy),       32'h0);
        check("rst_overrun", 32'(bus.overrun),    32'h0);

        // Reset mid-frame after 10 bits
        start_cycle(1'b0);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        check("mid_busy", 32'(bus.busy), 32'h1);
        do_clear(2);
        check("clr_pdata",   bus.PData,        32'h0);
        check("clr_pvalid",  32'(bus.PValid),  32'h0);
        check("clr_busy",    32'(bus.busy),    32'h0);
        check("clr_overrun", 32'(bus.overrun), 32'h0);
        send_bit(1'b1);
        check("idle_ignore_busy", 32'(bus.busy), 32'h0);

        // MSB first, contiguous
        exp_q.push_back(32'hA5C3_0F81);
        send_msb(32'hA5C3_0F81);
        check("msb_pvalid", 32'(bus.PValid), 32'h1);
        check("msb_pdata",  bus.PData,       32'hA5C3_0F81);
        check("msb_busy",   32'(bus.busy),   32'h0);
        tick();
        check("msb_taken", 32'(bus.PValid), 32'h0);

        // LSB first with gaps; bit 0 accepted in the start cycle
        begin
            logic [31:0] w;
            w = 32'h1234_5678;
            exp_q.push_back(w);
            bus.Dir    = 1'b1;
            bus.start  = 1'b1;
            bus.SValid = 1'b1;
            bus.SIn    = w[0];
            tick();
            bus.start  = 1'b0;
            bus.SValid = 1'b0;
            for (int i = 1; i < 32; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                send_bit(w[i]);
            end
            check("lsb_pdata",  bus.PData,       w);
            check("lsb_pvalid", 32'(bus.PValid), 32'h1);
            tick();
        end

        // Overrun: second word dropped while first is held
        bus.out_ready = 1'b0;
        exp_q.push_back(32'hDEAD_BEEF);
        send_msb(32'hDEAD_BEEF);
        check("ovr_first", bus.PData, 32'hDEAD_BEEF);
        check("ovr_none_yet", 32'(bus.overrun), 32'h0);
        send_msb(32'h0000_0001);
        check("ovr_pdata",   bus.PData,        32'hDEAD_BEEF);
        check("ovr_flag",    32'(bus.overrun), 32'h1);
        check("ovr_pvalid",  32'(bus.PValid),  32'h1);
        bus.out_ready = 1'b1;
        tick();
        check("ovr_taken",   32'(bus.PValid),  32'h0);
        check("ovr_sticky",  32'(bus.overrun), 32'h1);

        // Simultaneous accept and complete
        do_clear(1);
        bus.out_ready = 1'b0;
        exp_q.push_back(32'h1111_1111);
        send_msb(32'h1111_1111);
        check("sim_first", bus.PData, 32'h1111_1111);
        exp_q.push_back(32'h2222_2222);
        start_cycle(1'b0);
        begin
            logic [31:0] w;
            w = 32'h2222_2222;
            for (int i = 31; i >= 1; i--) send_bit(w[i]);
            bus.out_ready = 1'b1;
            send_bit(w[0]);
        end
        check("sim_pdata",   bus.PData,        32'h2222_2222);
        check("sim_pvalid",  32'(bus.PValid),  32'h1);
        check("sim_overrun", 32'(bus.overrun), 32'h0);
        tick();

        // Abort after 17 bits, then full frame
        start_cycle(1'b0);
        for (int i = 0; i < 17; i++) send_bit(1'b1);
        exp_q.push_back(32'hFFFF_0000);
        send_msb(32'hFFFF_0000);
        check("abort_pdata",  bus.PData,       32'hFFFF_0000);
        check("abort_pvalid", 32'(bus.PValid), 32'h1);
        check("abort_busy",   32'(bus.busy),   32'h0);

        repeat (4) tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
